// File: rtl/px_array_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : px_array_pkg
//  Description : Shared types and helper functions for the pixel-array ADC.
//  Revision    : 1.0  initial release
// ============================================================================
package px_array_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_READOUT = 3'd4
    } px_state_t;

    // Subtract that floors at zero instead of wrapping
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

    // Number of CONVERT cycles needed for the ramp to reach full scale
    function automatic int unsigned conv_cycles(input int unsigned vrst, input int unsigned step);
        return (vrst + step - 1) / step + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/px_channel.sv
`default_nettype none
// ============================================================================
//  Module      : px_channel
//  Description : One pixel: integrating node, single-slope comparator latch
//                and stored conversion code.
//  Revision    : 1.0  initial release
// ============================================================================
module px_channel
    import px_array_pkg::*;
#(
    parameter int ADC_W   = 8,
    parameter int LIGHT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_erase,
    input  logic               i_expose,
    input  logic               i_convert,
    input  logic [LIGHT_W-1:0] i_light,
    input  logic [ADC_W-1:0]   i_ramp,
    output logic [ADC_W-1:0]   o_code,
    output logic [ADC_W-1:0]   o_code_next
);

    localparam logic [ADC_W-1:0] c_VRST_CODE = '1;

    logic [ADC_W-1:0] r_node_q, w_node_d;
    logic [ADC_W-1:0] r_code_q, w_code_d;
    logic             r_latched_q, w_latched_d;

    // Next-state of node/code/latch for the current phase strobe
    always_comb begin
        w_node_d    = r_node_q;
        w_code_d    = r_code_q;
        w_latched_d = r_latched_q;
        if (i_erase) begin
            w_node_d    = c_VRST_CODE;
            w_code_d    = '0;
            w_latched_d = 1'b0;
        end else if (i_expose) begin
            w_node_d = ADC_W'(sat_sub(32'(r_node_q), 32'(i_light)));
        end else if (i_convert) begin
            // First ramp value at or above the node voltage is the code
            if (!r_latched_q && (i_ramp >= r_node_q)) begin
                w_code_d    = i_ramp;
                w_latched_d = 1'b1;
            end
        end
    end

    // Pixel state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_node_q    <= '0;
            r_code_q    <= '0;
            r_latched_q <= 1'b0;
        end else begin
            r_node_q    <= w_node_d;
            r_code_q    <= w_code_d;
            r_latched_q <= w_latched_d;
        end
    end

    assign o_code      = r_code_q;
    // Lets the readout register load a code that latches on the final ramp step
    assign o_code_next = w_code_d;

endmodule
`default_nettype wire

// File: rtl/px_array_adc.sv
`default_nettype none
// ============================================================================
//  Module      : px_array_adc
//  Description : Multi-pixel sensor model with shared single-slope ramp ADC
//                and valid/ready sequential readout.
//  Revision    : 1.0  initial release
// ============================================================================
module px_array_adc
    import px_array_pkg::*;
#(
    parameter  int N_PX      = 4,
    parameter  int ADC_W     = 8,
    parameter  int LIGHT_W   = 4,
    parameter  int RAMP_STEP = 1,
    parameter  int EXP_W     = 16,
    localparam int C_IDX_W   = (N_PX > 1) ? $clog2(N_PX) : 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    START,
    input  logic [EXP_W-1:0]        EXPOSE_CYCLES,
    input  logic [N_PX*LIGHT_W-1:0] PX_LIGHT,
    output logic [ADC_W-1:0]        DATA,
    output logic [C_IDX_W-1:0]      DATA_IDX,
    output logic                    DATA_VALID,
    input  logic                    DATA_READY,
    output logic                    BUSY,
    output logic                    DONE
);

    localparam logic [ADC_W-1:0]   c_VRST_CODE = '1;
    localparam logic [C_IDX_W-1:0] c_LAST_IDX  = C_IDX_W'(N_PX - 1);

    px_state_t          r_state_q, w_state_d;
    logic [EXP_W-1:0]   r_exp_len_q, w_exp_len_d;
    logic [EXP_W-1:0]   r_exp_cnt_q, w_exp_cnt_d;
    logic [ADC_W-1:0]   r_ramp_q, w_ramp_d;
    logic [C_IDX_W-1:0] r_idx_q, w_idx_d;
    logic [ADC_W-1:0]   r_data_q, w_data_d;
    logic               r_valid_q, w_valid_d;
    logic               r_busy_q, w_busy_d;
    logic               r_done_q, w_done_d;

    logic [ADC_W-1:0]   w_code [N_PX];
    logic [ADC_W-1:0]   w_code_next [N_PX];
    logic [ADC_W:0]     w_ramp_sum;
    logic [ADC_W-1:0]   w_ramp_adv;
    logic [C_IDX_W-1:0] w_idx_inc;

    genvar gi;
    generate
        for (gi = 0; gi < N_PX; gi++) begin : g_px
            px_channel #(
                .ADC_W   (ADC_W),
                .LIGHT_W (LIGHT_W)
            ) u_ch (
                .clk         (CLK),
                .rst         (RESET),
                .i_erase     (r_state_q == S_ERASE),
                .i_expose    (r_state_q == S_EXPOSE),
                .i_convert   (r_state_q == S_CONVERT),
                .i_light     (PX_LIGHT[gi*LIGHT_W +: LIGHT_W]),
                .i_ramp      (r_ramp_q),
                .o_code      (w_code[gi]),
                .o_code_next (w_code_next[gi])
            );
        end
    endgenerate

    // Ramp advance clamped at full scale; readout index increment
    always_comb begin
        w_ramp_sum = {1'b0, r_ramp_q} + (ADC_W+1)'(RAMP_STEP);
        w_ramp_adv = (w_ramp_sum > {1'b0, c_VRST_CODE}) ? c_VRST_CODE : w_ramp_sum[ADC_W-1:0];
        w_idx_inc  = r_idx_q + 1'b1;
    end

    // Frame sequencer and registered output next-state
    always_comb begin
        w_state_d   = r_state_q;
        w_exp_len_d = r_exp_len_q;
        w_exp_cnt_d = r_exp_cnt_q;
        w_ramp_d    = '0;
        w_idx_d     = r_idx_q;
        w_data_d    = r_data_q;
        w_valid_d   = 1'b0;
        w_done_d    = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (START) begin
                    w_state_d   = S_ERASE;
                    w_exp_len_d = EXPOSE_CYCLES;
                end
            end
            S_ERASE: begin
                w_exp_cnt_d = '0;
                w_state_d   = (r_exp_len_q == '0) ? S_CONVERT : S_EXPOSE;
            end
            S_EXPOSE: begin
                w_exp_cnt_d = r_exp_cnt_q + 1'b1;
                if (w_exp_cnt_d == r_exp_len_q) begin
                    w_state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (r_ramp_q == c_VRST_CODE) begin
                    w_state_d = S_READOUT;
                    w_idx_d   = '0;
                    w_valid_d = 1'b1;
                    w_data_d  = w_code_next[0];
                end else begin
                    w_ramp_d = w_ramp_adv;
                end
            end
            S_READOUT: begin
                w_valid_d = 1'b1;
                if (DATA_READY) begin
                    if (r_idx_q == c_LAST_IDX) begin
                        w_state_d = S_IDLE;
                        w_done_d  = 1'b1;
                        w_valid_d = 1'b0;
                        w_idx_d   = '0;
                        w_data_d  = '0;
                    end else begin
                        w_idx_d  = w_idx_inc;
                        w_data_d = w_code[w_idx_inc];
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase
        w_busy_d = (w_state_d != S_IDLE);
    end

    // Sequencer and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state_q   <= S_IDLE;
            r_exp_len_q <= '0;
            r_exp_cnt_q <= '0;
            r_ramp_q    <= '0;
            r_idx_q     <= '0;
            r_data_q    <= '0;
            r_valid_q   <= 1'b0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_exp_len_q <= w_exp_len_d;
            r_exp_cnt_q <= w_exp_cnt_d;
            r_ramp_q    <= w_ramp_d;
            r_idx_q     <= w_idx_d;
            r_data_q    <= w_data_d;
            r_valid_q   <= w_valid_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
        end
    end

    assign DATA       = r_data_q;
    assign DATA_IDX   = r_idx_q;
    assign DATA_VALID = r_valid_q;
    assign BUSY       = r_busy_q;
    assign DONE       = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_px_array_adc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_px_array_adc
//  Description : Self-checking bench for px_array_adc (RAMP_STEP 1 and 16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_px_array_adc;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        DATA_READY = 1'b1;
    logic [15:0] EXPOSE_CYCLES = '0;
    logic [15:0] PX_LIGHT = '0;

    logic [7:0] data_a, data_b;
    logic [1:0] idx_a, idx_b;
    logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b;

    int n_cmp = 0;
    int n_bad = 0;
    int obs_code[4];

    always #5 CLK = ~CLK;

    px_array_adc #(.N_PX(4), .ADC_W(8), .LIGHT_W(4), .RAMP_STEP(1), .EXP_W(16)) dut_a (
        .CLK(CLK), .RESET(RESET), .START(START), .EXPOSE_CYCLES(EXPOSE_CYCLES),
        .PX_LIGHT(PX_LIGHT), .DATA(data_a), .DATA_IDX(idx_a), .DATA_VALID(valid_a),
        .DATA_READY(DATA_READY), .BUSY(busy_a), .DONE(done_a));

    px_array_adc #(.N_PX(4), .ADC_W(8), .LIGHT_W(4), .RAMP_STEP(16), .EXP_W(16)) dut_b (
        .CLK(CLK), .RESET(RESET), .START(START), .EXPOSE_CYCLES(EXPOSE_CYCLES),
        .PX_LIGHT(PX_LIGHT), .DATA(data_b), .DATA_IDX(idx_b), .DATA_VALID(valid_b),
        .DATA_READY(DATA_READY), .BUSY(busy_b), .DONE(done_b));

    // Reference: node drains linearly from 255, floors at 0; code is the first
    // ramp value (multiples of step, capped at 255) not below the node.
    function automatic int model_code(input int e, input int l, input int step);
        int node;
        int c;
        node = 255 - e * l;
        if (node < 0) node = 0;
        c = ((node + step - 1) / step) * step;
        if (c > 255) c = 255;
        return c;
    endfunction

    function automatic int model_busy(input int e, input int step);
        return 1 + e + ((255 + step - 1) / step + 1) + 4;
    endfunction

    function automatic int light_of(input logic [15:0] lt, input int i);
        return int'(lt[i*4 +: 4]);
    endfunction

    // Run one frame and collect observations from the selected DUT.
    // rmode: 0 = ready held high, 1 = fixed stall pattern, 2 = random ready.
    task automatic do_frame(input int e, input logic [15:0] lt, input int rmode,
                            input bit s16, input bit poke,
                            output int bcyc, output int ndone, output int ntx,
                            output int stall_bad, output int order_bad,
                            output bit done_first_idle, output bit tout);
        int   pat[7] = '{0, 0, 1, 0, 1, 1, 1};
        int   rc = 0;
        int   after = -1;
        bit   seen = 0;
        logic pv = 0, pr = 0, rdy;
        logic [7:0] pd = 0, d;
        logic [1:0] pi = 0, ix;
        logic b, v, dn;
        bcyc = 0; ndone = 0; ntx = 0; stall_bad = 0; order_bad = 0;
        done_first_idle = 0; tout = 0;
        for (int k = 0; k < 4; k++) obs_code[k] = -1;
        @(negedge CLK);
        START = 1'b1; EXPOSE_CYCLES = e[15:0]; PX_LIGHT = lt; DATA_READY = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge CLK);
            START         = poke && (cyc == 40);
            EXPOSE_CYCLES = (poke && cyc == 40) ? 16'd3 : e[15:0];
            b  = s16 ? busy_b  : busy_a;
            v  = s16 ? valid_b : valid_a;
            dn = s16 ? done_b  : done_a;
            d  = s16 ? data_b  : data_a;
            ix = s16 ? idx_b   : idx_a;
            if (b) begin bcyc++; seen = 1; end
            if (dn) ndone++;
            if (seen && !b && after < 0) begin
                after = 0;
                done_first_idle = dn;
            end
            if (pv && !pr && (!v || d !== pd || ix !== pi)) stall_bad++;
            rdy = 1'b1;
            if (v) begin
                if (rmode == 1) begin
                    rdy = (rc < 7) ? pat[rc][0] : 1'b1;
                    rc++;
                end else if (rmode == 2) begin
                    rdy = $urandom_range(1, 0) == 1;
                end
            end
            DATA_READY = rdy;
            if (v && rdy) begin
                if (ntx < 4) obs_code[ntx] = int'(d);
                if (int'(ix) != ntx) order_bad++;
                ntx++;
            end
            pv = v; pr = rdy; pd = d; pi = ix;
            if (after >= 0) after++;
            if (after >= 3) break;
        end
        tout = (after < 0);
        START = 1'b0;
        DATA_READY = 1'b1;
        for (int k = 0; k < 600 && (busy_a || busy_b); k++) @(negedge CLK);
    endtask

    task automatic test_reset;
        RESET = 1'b1; START = 1'b1; EXPOSE_CYCLES = 16'd5;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({data_a, idx_a, valid_a, busy_a, done_a} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got data=%0d idx=%0d valid=%b busy=%b done=%b want all 0",
                     data_a, idx_a, valid_a, busy_a, done_a);
        end
        RESET = 1'b0; START = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (busy_a !== 1'b0 || done_a !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_no_frame: got busy=%b done=%b want 0 0", busy_a, done_a);
            end
        end
    endtask

    // Compare all four observed codes of a frame against the model
    task automatic test_frame(input string nm, input int e, input logic [15:0] lt,
                              input int rmode, input bit s16, input bit poke,
                              input bit chk_busy, input int busy_extra);
        int bc, nd, nt, sb, ob, step;
        bit dfi, to;
        step = s16 ? 16 : 1;
        do_frame(e, lt, rmode, s16, poke, bc, nd, nt, sb, ob, dfi, to);
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL %s_timeout: frame did not finish, busy cycles=%0d", nm, bc);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs_code[i] != model_code(e, light_of(lt, i), step)) begin
                n_bad++;
                $display("FAIL %s_code%0d: got %0d want %0d", nm, i, obs_code[i],
                         model_code(e, light_of(lt, i), step));
            end
        end
        n_cmp++;
        if (nt != 4 || ob != 0 || sb != 0) begin
            n_bad++;
            $display("FAIL %s_handshake: got transfers=%0d order_err=%0d stall_err=%0d want 4 0 0",
                     nm, nt, ob, sb);
        end
        n_cmp++;
        if (nd != 1 || !dfi) begin
            n_bad++;
            $display("FAIL %s_done: got pulses=%0d at_first_idle=%b want 1 1", nm, nd, dfi);
        end
        if (chk_busy) begin
            n_cmp++;
            if (bc != model_busy(e, step) + busy_extra) begin
                n_bad++;
                $display("FAIL %s_busy_len: got %0d want %0d", nm, bc, model_busy(e, step) + busy_extra);
            end
        end
    endtask

    task automatic test_basic;
        test_frame("basic", 10, 16'hF510, 0, 1'b0, 1'b0, 1'b1, 0);
    endtask

    task automatic test_saturation;
        test_frame("sat", 20, 16'h70FF, 0, 1'b0, 1'b0, 1'b1, 0);
        test_frame("zero_exp", 0, 16'hF510, 0, 1'b0, 1'b0, 1'b1, 0);
    endtask

    task automatic test_ramp16;
        test_frame("ramp16", 10, 16'hF510, 0, 1'b1, 1'b0, 1'b1, 0);
    endtask

    task automatic test_backpressure;
        // three stall cycles in the pattern lengthen BUSY by 3
        test_frame("backpr", 10, 16'hF510, 1, 1'b0, 1'b1, 1'b1, 3);
    endtask

    task automatic test_reset_mid_convert;
        @(negedge CLK);
        START = 1'b1; EXPOSE_CYCLES = 16'd10; PX_LIGHT = 16'hF510;
        @(negedge CLK);
        START = 1'b0;
        repeat (30) @(negedge CLK);
        n_cmp++;
        if (busy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL midconv_busy: got %b want 1", busy_a);
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        n_cmp++;
        if ({data_a, idx_a, valid_a, busy_a, done_a} !== 13'd0) begin
            n_bad++;
            $display("FAIL midconv_reset: got data=%0d idx=%0d valid=%b busy=%b done=%b want all 0",
                     data_a, idx_a, valid_a, busy_a, done_a);
        end
        begin
            int seen_act = 0;
            for (int k = 0; k < 300; k++) begin
                @(negedge CLK);
                if (busy_a || done_a || valid_a) seen_act++;
            end
            n_cmp++;
            if (seen_act != 0) begin
                n_bad++;
                $display("FAIL midconv_quiet: got %0d active cycles want 0", seen_act);
            end
        end
        test_frame("fresh", 10, 16'hF510, 0, 1'b0, 1'b0, 1'b1, 0);
    endtask

    task automatic test_random;
        for (int f = 0; f < 6; f++) begin
            int e;
            logic [15:0] lt;
            e  = $urandom_range(40, 0);
            lt = 16'($urandom);
            test_frame("rand", e, lt, 2, f[0], 1'b0, 1'b0, 0);
        end
    endtask

    task automatic test_back_to_back;
        // START held across the DONE cycle starts the next frame immediately
        int gap = -1;
        @(negedge CLK);
        START = 1'b1; EXPOSE_CYCLES = 16'd0; PX_LIGHT = 16'h0000; DATA_READY = 1'b1;
        for (int k = 0; k < 700; k++) begin
            @(negedge CLK);
            if (done_a) begin
                @(negedge CLK);
                START = 1'b0;
                gap = busy_a ? 1 : 0;
                break;
            end
        end
        START = 1'b0;
        n_cmp++;
        if (gap != 1) begin
            n_bad++;
            $display("FAIL back_to_back: got restart=%0d want 1", gap);
        end
        for (int k = 0; k < 700 && (busy_a || busy_b); k++) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_ramp16();
        test_backpressure();
        test_reset_mid_convert();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/px_array_adc.md
# px_array_adc

Parametrised multi-pixel sensor model with a shared single-slope ramp ADC and a sequential readout port. It runs an erase / expose / convert / readout frame sequence. Each of N_PX pixel nodes is precharged to full scale and drained per clock by its light input. All nodes are then digitised against one shared ramp counter, and the codes are streamed out over a valid/ready handshake. It sits between the pixel stimulus and the frame-capture logic as the next-generation array sensor model.

## Interface
- N_PX, 4, number of pixels (channels), >= 1
- ADC_W, 8, node/code width; full scale VRST_CODE = 2^ADC_W-1
- LIGHT_W, 4, per-pixel light intensity width
- RAMP_STEP, 1, ramp increment per convert cycle, 1..VRST_CODE
- EXP_W, 16, width of exposure-length input
- CLK  in  1  clock; one clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  frame request; sampled only in IDLE
- EXPOSE_CYCLES  in  EXP_W  exposure length in clocks, latched at START
- PX_LIGHT  in  N_PX*LIGHT_W  pixel i intensity at bits [i*LIGHT_W +: LIGHT_W]
- DATA  out  ADC_W  pixel code being presented
- DATA_IDX  out  $clog2(N_PX) (min 1)  index of presented pixel
- DATA_VALID  out  1  DATA/DATA_IDX valid
- DATA_READY  in  1  consumer accepts
- BUSY  out  1  frame in progress (state != IDLE)
- DONE  out  1  one-cycle pulse, frame complete

## Operation
- FSM states: IDLE, ERASE, EXPOSE, CONVERT, READOUT.
- IDLE:
  - BUSY=0.
  - START=1 -> ERASE, latching EXPOSE_CYCLES into exp_len.
- ERASE (1 cycle):
  - Every node[i] set to VRST_CODE, code[i] to 0, latched[i] to 0.
  - exp_cnt set to 0.
  - Next state is EXPOSE, or CONVERT if exp_len==0.
- EXPOSE:
  - Each cycle: node[i] = node[i]-light[i], saturating at 0 (no wrap).
  - exp_cnt increments each cycle.
  - After exactly exp_len cycles -> CONVERT, with ramp set to 0.
- CONVERT:
  - Each cycle, every pixel with !latched[i] and ramp >= node[i] sets code[i]=ramp and latched[i]=1.
  - ramp then advances by RAMP_STEP, clamped to VRST_CODE. There is no wrap.
  - The cycle comparing ramp==VRST_CODE is the last CONVERT cycle; all pixels are latched by then.
  - Convert length C = ceil(VRST_CODE/RAMP_STEP)+1 cycles.
  - Next state is READOUT, with idx set to 0.
- READOUT:
  - DATA_VALID=1, DATA=code[idx], DATA_IDX=idx.
  - A transfer occurs on a cycle with DATA_VALID && DATA_READY; idx then increments.
  - The transfer at idx==N_PX-1 -> IDLE with DONE=1 for that next cycle.
- START while BUSY is ignored. PX_LIGHT changes are honoured cycle by cycle during EXPOSE and ignored in other states.
- RESET (any state) -> next cycle:
  - State IDLE.
  - All outputs 0: DATA=0, DATA_IDX=0, DATA_VALID=0, BUSY=0, DONE=0.
  - Nodes/codes 0, latched 0, counters 0.
  - RESET dominates START in the same cycle.

## Timing
- All outputs registered; no combinational input-to-output paths.
- START sampled at edge k: ERASE occupies cycle k+1, EXPOSE the next E cycles, CONVERT the next C cycles, READOUT the next N_PX cycles if DATA_READY is held 1.
- With DATA_READY tied high, BUSY is high for 1+E+C+N_PX cycles. DONE is high in the first IDLE cycle, together with BUSY=0.
- DATA, DATA_IDX and DATA_VALID hold stable while DATA_VALID && !DATA_READY.
- A back-to-back START is accepted in the DONE cycle.

## Structure
- Package px_array_pkg holds:
  - typedef enum px_state_t {S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READOUT}
  - function sat_sub (saturating subtract)
  - function conv_cycles (computes C)
- Sub-module px_channel, one per pixel via generate.
  - Holds node, code and latched.
  - Inputs: erase, expose, convert strobes, light, ramp.
- The top holds the FSM, exp_cnt, ramp, idx and the readout mux.

## Test plan
All scenarios use N_PX=4, ADC_W=8, LIGHT_W=4, RAMP_STEP=1 unless stated.
- Reset: RESET high 2 cycles, START=1 -> all outputs 0, BUSY=0; no frame starts.
- Basic frame: EXPOSE_CYCLES=10, light {0,1,5,15}, DATA_READY=1 -> codes 255,245,205,105 at idx 0..3. BUSY high 1+10+256+4=271 cycles. DONE is one cycle.
- Saturation and zero exposure:
  - EXPOSE_CYCLES=20, light 15 -> code 0.
  - EXPOSE_CYCLES=0 -> all codes 255, BUSY 261 cycles.
- RAMP_STEP=16, EXPOSE_CYCLES=10, light {0,1,5,15} -> codes 255,255,208,112. CONVERT lasts 17 cycles.
- Backpressure: DATA_READY pattern 0,0,1,0,1,1,1 in READOUT -> DATA/DATA_IDX stable during stalls, four transfers in order. A START pulse mid-frame is ignored.
- Reset mid-CONVERT -> IDLE next cycle with DATA_VALID=0 and no DONE. A following START with EXPOSE_CYCLES=10 yields the correct fresh codes.
